// File: rtl/clk_sched_pkg.sv
// ---------------------------------------------------------------------------
// clk_sched_pkg
//   Shared types and defaults for the clock-divider scheduler.
//   NUM_CH_DEF  default number of divide channels (legal range 2..8)
//   CNT_W_DEF   default width of the half-period counter and cfg_div
//   ch_state_t  per-channel run state
//   cfg_t       one configuration word as seen by a channel
//                 (div = half-period minus 1, en = run/stop)
// ---------------------------------------------------------------------------
package clk_sched_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    CH_OFF  = 2'd0,
    CH_RUN  = 2'd1,
    CH_PEND = 2'd2
  } ch_state_t;

  // The div field is sized by the package default. A build that changes the
  // counter width changes CNT_W_DEF so that the struct and the datapath agree.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] div;
    logic                 en;
  } cfg_t;

endpackage

// File: rtl/clk_sched_ch.sv
// ---------------------------------------------------------------------------
// clk_sched_ch
//   One divide channel: half-period counter, output toggle, tick strobe,
//   shadow config register and run-state machine. A new config taken while
//   running is held in the shadow register and applied only on the falling
//   toggle, so a period is never truncated or stretched mid-way.
//
//   Ports
//     CLK_in        source clock
//     RST           asynchronous, active-high reset
//     acc_i         config word accepted for this channel this cycle
//     cfg_i         config word (div, en)
//     align_wait_i  enable-from-OFF must wait for the reference tick
//     align_tick_i  reference tick (channel 0) used to release a waiting start
//     clk_o         divided clock, 50% duty
//     tick_o        one-cycle strobe with each clk_o rising edge
//     wait_o        enabled from OFF, waiting for the reference tick
//     state_o       current run state
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   CH_OFF  | stopped, clk_o held 0 (may be waiting for an aligned start)
//   CH_RUN  | counting, no config outstanding
//   CH_PEND | counting, shadow config waits for the next falling toggle
// ---------------------------------------------------------------------------
module clk_sched_ch
  import clk_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic      CLK_in,
  input  logic      RST,
  input  logic      acc_i,
  input  cfg_t      cfg_i,
  input  logic      align_wait_i,
  input  logic      align_tick_i,
  output logic      clk_o,
  output logic      tick_o,
  output logic      wait_o,
  output ch_state_t state_o
);

  ch_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] div_q;
  cfg_t             shadow_q;
  logic             clk_q;
  logic             tick_q;
  logic             wait_q;

  logic             term;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] start_cnt_d;

  assign term  = (cnt_q == div_q);
  assign cnt_d = term ? '0 : cnt_q + CNT_W'(1);

  // An aligned start happens the cycle after the reference tick, so the
  // counter is preloaded with 1 to account for the tick cycle already spent.
  // With div=0 there is no room for that preload and counting starts at 0.
  assign start_cnt_d = (div_q == '0) ? '0 : CNT_W'(1);

  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      state_q  <= CH_OFF;
      cnt_q    <= '0;
      div_q    <= '0;
      shadow_q <= '0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      wait_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      unique case (state_q)
        CH_OFF: begin
          if (acc_i) begin
            div_q <= cfg_i.div;
            if (cfg_i.en) begin
              if (align_wait_i) begin
                wait_q <= 1'b1;
              end else begin
                state_q <= CH_RUN;
                cnt_q   <= '0;
                clk_q   <= 1'b0;
              end
            end
          end else if (wait_q) begin
            if (align_tick_i) begin
              state_q <= CH_RUN;
              cnt_q   <= start_cnt_d;
              clk_q   <= 1'b0;
              wait_q  <= 1'b0;
            end else if (!align_wait_i) begin
              // Reference channel stopped while we waited: start right away.
              state_q <= CH_RUN;
              cnt_q   <= '0;
              clk_q   <= 1'b0;
              wait_q  <= 1'b0;
            end
          end
        end

        CH_RUN, CH_PEND: begin
          cnt_q <= cnt_d;
          if (term) begin
            clk_q  <= ~clk_q;
            tick_q <= ~clk_q;
            // Falling toggle closes a full period: the only apply point.
            if (clk_q && (state_q == CH_PEND)) begin
              div_q   <= shadow_q.div;
              state_q <= shadow_q.en ? CH_RUN : CH_OFF;
            end
          end
          // A pending channel never sees acc_i (its ready is low), so accept
          // and apply cannot collide.
          if (acc_i && (state_q == CH_RUN)) begin
            shadow_q <= cfg_i;
            state_q  <= CH_PEND;
          end
        end

        default: begin
          state_q <= CH_OFF;
          clk_q   <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign clk_o   = clk_q;
  assign tick_o  = tick_q;
  assign wait_o  = wait_q;
  assign state_o = state_q;

endmodule

// File: rtl/clk_sched_ctrl.sv
// ---------------------------------------------------------------------------
// clk_sched_ctrl
//   Run-time controller for NUM_CH independent clock-divide channels.
//   Config words arrive over a valid/ready port; each accepted word is routed
//   to one channel, which applies it at its next period boundary.
//   Words addressed to a non-existent channel are accepted and dropped.
//
//   Build option
//     CLK_SCHED_PHASE_ALIGN_EN  when defined, a channel other than 0 enabled
//                               from OFF waits (pend=1) for the next tick of
//                               channel 0 and starts the cycle after it, so
//                               rising edges line up with channel 0. If
//                               channel 0 is OFF the start is immediate.
//
//   Ports
//     CLK_in       source clock
//     RST          asynchronous, active-high reset
//     cfg_valid_i  config request present
//     cfg_ready_o  config can be accepted (combinational on cfg_ch_i)
//     cfg_ch_i     target channel
//     cfg_div_i    half-period minus 1
//     cfg_en_i     1 = run channel, 0 = stop channel
//     clk_out_o    divided clocks, one per channel
//     tick_o       one-cycle strobes, coincident with clk_out_o rising
//     pend_o       channel holds an accepted, not-yet-applied config
// ---------------------------------------------------------------------------
module clk_sched_ctrl
  import clk_sched_pkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEF,
  parameter  int CNT_W  = CNT_W_DEF,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              CLK_in,
  input  logic              RST,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [CNT_W-1:0]  cfg_div_i,
  input  logic              cfg_en_i,
  output logic [NUM_CH-1:0] clk_out_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] pend_o
);

  cfg_t              cfg_in;
  ch_state_t         ch_state [NUM_CH];
  logic [NUM_CH-1:0] ch_wait;
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] acc;
  logic [NUM_CH-1:0] align_wait;
  logic [NUM_CH-1:0] align_tick;

  assign cfg_in.div = cfg_div_i;
  assign cfg_in.en  = cfg_en_i;

  // One-hot address decode. An out-of-range channel selects nothing, which
  // makes it always ready and drops the word.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch_i == CH_W'(i)) begin
        sel[i] = 1'b1;
      end
    end
  end

  assign cfg_ready_o = ~|(sel & pend_o);
  assign acc         = sel & {NUM_CH{cfg_valid_i & cfg_ready_o}};

`ifdef CLK_SCHED_PHASE_ALIGN_EN
  // Channel 0 is the phase reference and always starts immediately.
  always_comb begin
    align_wait = '0;
    align_tick = '0;
    for (int i = 1; i < NUM_CH; i++) begin
      align_wait[i] = (ch_state[0] != CH_OFF);
      align_tick[i] = tick_o[0];
    end
  end
`else
  assign align_wait = '0;
  assign align_tick = '0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_sched_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .CLK_in       (CLK_in),
      .RST          (RST),
      .acc_i        (acc[i]),
      .cfg_i        (cfg_in),
      .align_wait_i (align_wait[i]),
      .align_tick_i (align_tick[i]),
      .clk_o        (clk_out_o[i]),
      .tick_o       (tick_o[i]),
      .wait_o       (ch_wait[i]),
      .state_o      (ch_state[i])
    );

    // A waiting aligned start also counts as pending so the port stalls it.
    assign pend_o[i] = (ch_state[i] == CH_PEND) || ch_wait[i];
  end

endmodule

// File: tb/tb_clk_sched_ctrl.sv
module tb_clk_sched_ctrl;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;

  logic              CLK_in = 1'b0;
  logic              RST    = 1'b1;
  logic              cfg_valid_i = 1'b0;
  logic              cfg_ready_o;
  logic [CH_W-1:0]   cfg_ch_i  = '0;
  logic [CNT_W-1:0]  cfg_div_i = '0;
  logic              cfg_en_i  = 1'b0;
  logic [NUM_CH-1:0] clk_out_o;
  logic [NUM_CH-1:0] tick_o;
  logic [NUM_CH-1:0] pend_o;

  int vec  = 0;
  int miss = 0;

  always #5 CLK_in = ~CLK_in;

  clk_sched_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .CLK_in      (CLK_in),
    .RST         (RST),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_ch_i    (cfg_ch_i),
    .cfg_div_i   (cfg_div_i),
    .cfg_en_i    (cfg_en_i),
    .clk_out_o   (clk_out_o),
    .tick_o      (tick_o),
    .pend_o      (pend_o)
  );

  task automatic step();
    @(posedge CLK_in);
    #1;
  endtask

  task automatic do_reset();
    cfg_valid_i = 1'b0;
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    step();
  endtask

  task automatic drive(input int ch, input int div, input logic en);
    cfg_valid_i = 1'b1;
    cfg_ch_i    = CH_W'(ch);
    cfg_div_i   = CNT_W'(div);
    cfg_en_i    = en;
  endtask

  // Returns 1 time unit after the edge that accepted the word (n = 0).
  task automatic send(input int ch, input int div, input logic en);
    int waited;
    waited = 0;
    drive(ch, div, en);
    #1;
    while (!cfg_ready_o && waited < 50) begin
      step();
      waited++;
    end
    vec++;
    if (cfg_ready_o !== 1'b1) begin
      miss++;
      $display("FAIL send_ready ch=%0d got %0b exp 1 (timeout)", ch, cfg_ready_o);
    end
    step();
    cfg_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    cfg_ch_i = '0;
    step();
    step();
    vec++; if (clk_out_o !== 4'b0000) begin miss++; $display("FAIL reset_clk got %b exp 0000", clk_out_o); end
    vec++; if (tick_o !== 4'b0000) begin miss++; $display("FAIL reset_tick got %b exp 0000", tick_o); end
    vec++; if (pend_o !== 4'b0000) begin miss++; $display("FAIL reset_pend got %b exp 0000", pend_o); end
    vec++; if (cfg_ready_o !== 1'b1) begin miss++; $display("FAIL reset_ready got %0b exp 1", cfg_ready_o); end
    RST = 1'b0;
    step();
  endtask

  // ch0 div=4: tick 5 cycles after accept, 5 high / 5 low.
  task automatic test_ch0_div4();
    logic e_clk, e_tick;
    do_reset();
    send(0, 4, 1'b1);
    for (int n = 0; n < 25; n++) begin
      if (n > 0) step();
      e_clk  = (n >= 5) && (((n - 5) / 5) % 2 == 0);
      e_tick = (n >= 5) && ((n - 5) % 10 == 0);
      vec++; if (clk_out_o[0] !== e_clk) begin miss++; $display("FAIL ch0_clk n=%0d got %0b exp %0b", n, clk_out_o[0], e_clk); end
      vec++; if (tick_o[0] !== e_tick) begin miss++; $display("FAIL ch0_tick n=%0d got %0b exp %0b", n, tick_o[0], e_tick); end
      vec++; if (pend_o[0] !== 1'b0) begin miss++; $display("FAIL ch0_pend n=%0d got %0b exp 0", n, pend_o[0]); end
    end
  endtask

  // ch1 div=2, new div=9 in the high phase; applied at the falling toggle.
  task automatic test_reprogram();
    logic e_clk, e_tick, e_pend;
    do_reset();
    send(1, 2, 1'b1);
    for (int n = 0; n < 35; n++) begin
      if (n > 0) step();
      if (n < 10)      e_clk = (n >= 3) && (((n - 3) / 3) % 2 == 0);
      else if (n < 12) e_clk = 1'b1;
      else if (n < 22) e_clk = 1'b0;
      else if (n < 32) e_clk = 1'b1;
      else             e_clk = 1'b0;
      e_tick = (n == 3) || (n == 9) || (n == 22);
      e_pend = (n == 10) || (n == 11);
      vec++; if (clk_out_o[1] !== e_clk) begin miss++; $display("FAIL reprog_clk n=%0d got %0b exp %0b", n, clk_out_o[1], e_clk); end
      vec++; if (tick_o[1] !== e_tick) begin miss++; $display("FAIL reprog_tick n=%0d got %0b exp %0b", n, tick_o[1], e_tick); end
      vec++; if (pend_o[1] !== e_pend) begin miss++; $display("FAIL reprog_pend n=%0d got %0b exp %0b", n, pend_o[1], e_pend); end
      if (n == 9) drive(1, 9, 1'b1);
      if (n == 10) begin
        cfg_valid_i = 1'b0;
        #1;
        vec++; if (cfg_ready_o !== 1'b0) begin miss++; $display("FAIL reprog_ready_ch1 got %0b exp 0", cfg_ready_o); end
        cfg_ch_i = 2'd2;
        #1;
        vec++; if (cfg_ready_o !== 1'b1) begin miss++; $display("FAIL reprog_ready_ch2 got %0b exp 1", cfg_ready_o); end
        cfg_ch_i = 2'd1;
      end
      if (n == 12) begin
        vec++; if (cfg_ready_o !== 1'b1) begin miss++; $display("FAIL reprog_ready_after got %0b exp 1", cfg_ready_o); end
      end
    end
  endtask

  // ch2 div=0 then disabled: runs to the next falling toggle, then stays 0.
  task automatic test_disable();
    logic e_clk, e_tick, e_pend;
    do_reset();
    send(2, 0, 1'b1);
    for (int n = 0; n < 12; n++) begin
      if (n > 0) step();
      e_clk  = (n == 1) || (n == 3);
      e_tick = (n == 1) || (n == 3);
      e_pend = (n == 2) || (n == 3);
      vec++; if (clk_out_o[2] !== e_clk) begin miss++; $display("FAIL dis_clk n=%0d got %0b exp %0b", n, clk_out_o[2], e_clk); end
      vec++; if (tick_o[2] !== e_tick) begin miss++; $display("FAIL dis_tick n=%0d got %0b exp %0b", n, tick_o[2], e_tick); end
      vec++; if (pend_o[2] !== e_pend) begin miss++; $display("FAIL dis_pend n=%0d got %0b exp %0b", n, pend_o[2], e_pend); end
      if (n == 1) drive(2, 0, 1'b0);
      if (n == 2) cfg_valid_i = 1'b0;
    end
  endtask

  // Second word to a pending channel stalls until apply, accepted next edge.
  task automatic test_back_to_back();
    logic e_clk, e_tick, e_pend;
    do_reset();
    send(3, 1, 1'b1);
    for (int n = 0; n < 15; n++) begin
      if (n > 0) step();
      if (n < 4)       e_clk = (n >= 2);
      else if (n < 8)  e_clk = 1'b0;
      else if (n < 12) e_clk = 1'b1;
      else             e_clk = (n == 13);
      e_tick = (n == 2) || (n == 8) || (n == 13);
      e_pend = (n == 3) || (n >= 5 && n <= 11);
      vec++; if (clk_out_o[3] !== e_clk) begin miss++; $display("FAIL b2b_clk n=%0d got %0b exp %0b", n, clk_out_o[3], e_clk); end
      vec++; if (tick_o[3] !== e_tick) begin miss++; $display("FAIL b2b_tick n=%0d got %0b exp %0b", n, tick_o[3], e_tick); end
      vec++; if (pend_o[3] !== e_pend) begin miss++; $display("FAIL b2b_pend n=%0d got %0b exp %0b", n, pend_o[3], e_pend); end
      if (n == 2) drive(3, 3, 1'b1);
      if (n == 3) begin
        drive(3, 0, 1'b1);
        #1;
        vec++; if (cfg_ready_o !== 1'b0) begin miss++; $display("FAIL b2b_stall got %0b exp 0", cfg_ready_o); end
      end
      if (n == 4) begin
        vec++; if (cfg_ready_o !== 1'b1) begin miss++; $display("FAIL b2b_release got %0b exp 1", cfg_ready_o); end
      end
      if (n == 5) cfg_valid_i = 1'b0;
    end
  endtask

  // Async reset with ch0 high and ch3 pending; nothing restarts afterwards.
  task automatic test_rst_mid();
    do_reset();
    send(0, 4, 1'b1);
    drive(3, 5, 1'b1);
    step();
    cfg_valid_i = 1'b0;
    for (int n = 2; n <= 7; n++) step();
    vec++; if (tick_o[3] !== 1'b1) begin miss++; $display("FAIL rst_ch3_tick got %0b exp 1", tick_o[3]); end
    drive(3, 1, 1'b1);
    step();
    cfg_valid_i = 1'b0;
    vec++; if (clk_out_o[0] !== 1'b1) begin miss++; $display("FAIL rst_pre_ch0 got %0b exp 1", clk_out_o[0]); end
    vec++; if (pend_o[3] !== 1'b1) begin miss++; $display("FAIL rst_pre_pend3 got %0b exp 1", pend_o[3]); end
    #2;
    RST = 1'b1;
    #1;
    vec++; if (clk_out_o !== 4'b0000) begin miss++; $display("FAIL rst_async_clk got %b exp 0000", clk_out_o); end
    vec++; if (pend_o !== 4'b0000) begin miss++; $display("FAIL rst_async_pend got %b exp 0000", pend_o); end
    vec++; if (tick_o !== 4'b0000) begin miss++; $display("FAIL rst_async_tick got %b exp 0000", tick_o); end
    #2;
    RST = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      vec++; if ((clk_out_o | tick_o | pend_o) !== 4'b0000) begin miss++; $display("FAIL rst_after n=%0d clk=%b tick=%b pend=%b exp all 0", n, clk_out_o, tick_o, pend_o); end
    end
  endtask

  // ch0 div=1 running, ch1 div=3 enabled from OFF.
  task automatic test_align();
    logic e_t0, e_t1, e_c1, e_p1;
    do_reset();
    send(0, 1, 1'b1);
    for (int n = 0; n < 31; n++) begin
      if (n > 0) step();
      e_t0 = (n >= 2) && ((n - 2) % 4 == 0);
`ifdef CLK_SCHED_PHASE_ALIGN_EN
      e_t1 = (n == 10) || (n == 18) || (n == 26);
      e_c1 = (n >= 10) && (((n - 10) / 4) % 2 == 0);
      e_p1 = (n >= 4) && (n <= 6);
`else
      e_t1 = (n == 8) || (n == 16) || (n == 24);
      e_c1 = (n >= 8) && (((n - 8) / 4) % 2 == 0);
      e_p1 = 1'b0;
`endif
      vec++; if (tick_o[0] !== e_t0) begin miss++; $display("FAIL align_tick0 n=%0d got %0b exp %0b", n, tick_o[0], e_t0); end
      vec++; if (tick_o[1] !== e_t1) begin miss++; $display("FAIL align_tick1 n=%0d got %0b exp %0b", n, tick_o[1], e_t1); end
      vec++; if (clk_out_o[1] !== e_c1) begin miss++; $display("FAIL align_clk1 n=%0d got %0b exp %0b", n, clk_out_o[1], e_c1); end
      vec++; if (pend_o[1] !== e_p1) begin miss++; $display("FAIL align_pend1 n=%0d got %0b exp %0b", n, pend_o[1], e_p1); end
      if (n == 3) drive(1, 3, 1'b1);
      if (n == 4) cfg_valid_i = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired, simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ch0_div4();
    test_reprogram();
    test_disable();
    test_back_to_back();
    test_rst_mid();
    test_align();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
